exhaustive_vector_sweeper: RTL and testbench

//   Synthesisable exhaustive stimulus sequencer and checker for small combinational DUTs.

---
 rtl/exhaustive_vector_sweeper.sv | 121 ++++++++++++
 tb/tb_exhaustive_vector_sweeper.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : exhaustive_vector_sweeper
// Brief   : Drives every N_IN-bit vector in ascending order, holds each one
//           for HOLD cycles and compares the DUT response with a golden model.
// Revision: 1.0 - initial release
// ============================================================================
module exhaustive_vector_sweeper #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int HOLD  = 25,
    parameter int CNT_W = N_IN + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] resp,
    input  logic [N_OUT-1:0] expected,
    output logic             busy,
    output logic             sweep_tick,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_vld
);

    localparam int              HC_W        = $clog2(HOLD);
    localparam logic [HC_W-1:0] C_HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [N_IN-1:0] C_STIM_LAST = '1;
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [HC_W-1:0] r_hold_cnt;

    logic             w_sample;
    logic             w_mismatch;
    logic             w_last;
    logic [CNT_W-1:0] w_err_next;

    assign w_sample   = (r_hold_cnt == C_HOLD_LAST);
    assign w_mismatch = (resp != expected);
    assign w_last     = (stim == C_STIM_LAST);
    // Saturating increment; pass at sweep end must include the final sample.
    assign w_err_next = (w_mismatch && (err_cnt != C_CNT_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            stim          <= '0;
            busy          <= 1'b0;
            sweep_tick    <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else begin
            sweep_tick <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_SWEEP;
                        r_hold_cnt    <= '0;
                        stim          <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_vec <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (w_sample) begin
                        r_hold_cnt <= '0;
                        if (w_mismatch) begin
                            err_cnt <= w_err_next;
                            if (!first_err_vld) begin
                                first_err_vec <= stim;
                                first_err_vld <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            sweep_tick <= 1'b1;
                            if (loop) begin
                                stim <= '0;
                            end else begin
                                r_state <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass    <= (w_err_next == '0);
                            end
                        end else begin
                            stim <= stim + N_IN'(1);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_vector_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_exhaustive_vector_sweeper
// Brief   : Directed-vector bench for exhaustive_vector_sweeper.
// Revision: 1.0 - initial release
// ============================================================================
module tb_exhaustive_vector_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, loop = 1'b0;
    logic [2:0] stim;
    logic [1:0] resp, expected;
    logic       busy, sweep_tick, done, pass, first_err_vld;
    logic [4:0] err_cnt;
    logic [2:0] first_err_vec;
    logic [7:0] bad_mask = 8'h00;

    logic       start2 = 1'b0, abort2 = 1'b0, loop2 = 1'b0;
    logic [1:0] stim2, resp2, expected2;
    logic       busy2, sweep_tick2, done2, pass2, first_err_vld2;
    logic [2:0] err_cnt2;
    logic [1:0] first_err_vec2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Golden model: resp follows stim; expected is inverted on flagged vectors.
    always_comb begin
        resp      = stim[1:0];
        expected  = bad_mask[stim] ? ~stim[1:0] : stim[1:0];
        resp2     = stim2;
        expected2 = ~stim2;
    end

    exhaustive_vector_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(4), .CNT_W(5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .stim(stim), .resp(resp), .expected(expected), .busy(busy),
        .sweep_tick(sweep_tick), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_vld(first_err_vld)
    );

    exhaustive_vector_sweeper #(.N_IN(2), .N_OUT(2), .HOLD(2), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .loop(loop2),
        .stim(stim2), .resp(resp2), .expected(expected2), .busy(busy2),
        .sweep_tick(sweep_tick2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_vec(first_err_vec2), .first_err_vld(first_err_vld2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npulse;
        tick(2);
        chk("reset_outputs", {stim, busy, sweep_tick, done, pass, err_cnt, first_err_vec, first_err_vld}, 0);
        rst = 1'b0;
        tick(2);

        // T1: clean sweep
        pulse_start();
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 8; k++) begin
            chk("t1_stim", stim, k);
            tick(4);
        end
        chk("t1_done", {done, sweep_tick, busy, pass}, 4'b1101);
        chk("t1_err", err_cnt, 0);
        chk("t1_stim_hold", stim, 7);

        // T2: mismatch on vector 5 only
        bad_mask = 8'b0010_0000;
        pulse_start();
        tick(32);
        chk("t2_done", {done, pass}, 2'b10);
        chk("t2_err", err_cnt, 1);
        chk("t2_first", {first_err_vld, first_err_vec}, {1'b1, 3'd5});

        // start+abort together in DONE: start wins and clears results
        bad_mask = 8'h00;
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("t6_restart", {busy, done, pass, first_err_vld}, 4'b1000);
        chk("t6_err_clr", err_cnt, 0);
        // T6: start during SWEEP is ignored
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("t6_stim_e8", stim, 2);
        tick(23);
        chk("t6_not_done_31", done, 0);
        tick(1);
        chk("t6_done_32", {done, sweep_tick, pass}, 3'b111);
        tick(1);
        chk("t6_tick_width", sweep_tick, 0);

        // abort beats the sample pending in the same cycle
        bad_mask = 8'b0000_0001;
        pulse_start();
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_discard", {busy, done, first_err_vld}, 3'b000);
        chk("abort_err", err_cnt, 0);

        // T3: continuous loop, mismatch at vector 2
        bad_mask = 8'b0000_0100;
        loop = 1'b1;
        pulse_start();
        npulse = 0;
        for (int i = 1; i <= 96; i++) begin
            tick(1);
            if (sweep_tick) begin
                npulse++;
                chk("t3_tick_pos", i, npulse * 32);
                chk("t3_loop_state", {busy, done}, 2'b10);
            end
        end
        chk("t3_npulse", npulse, 3);
        chk("t3_err", err_cnt, 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        loop = 1'b0;
        chk("t3_abort", {busy, done}, 2'b00);
        chk("t3_first", {first_err_vld, first_err_vec}, {1'b1, 3'd2});
        tick(8);
        chk("t3_frozen", err_cnt, 3);

        // T5: asynchronous reset mid-sweep
        bad_mask = 8'b0000_0001;
        pulse_start();
        tick(10);
        chk("t5_pre_err", err_cnt, 1);
        rst = 1'b1;
        #1;
        chk("t5_async_rst", {stim, busy, sweep_tick, done, pass, err_cnt, first_err_vec, first_err_vld}, 0);
        tick(1);
        rst = 1'b0;
        bad_mask = 8'h00;
        pulse_start();
        tick(32);
        chk("t5_clean", {done, pass, err_cnt}, {2'b11, 5'd0});

        // T4: saturation on the small instance, every vector mismatches
        loop2 = 1'b1;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(12);
        chk("t4_err_6", err_cnt2, 6);
        tick(2);
        chk("t4_err_sat", err_cnt2, 7);
        tick(10);
        chk("t4_err_hold", {err_cnt2, busy2, done2}, {3'd7, 2'b10});
        chk("t4_first", {first_err_vld2, first_err_vec2}, {1'b1, 2'd0});
        abort2 = 1'b1;
        tick(1);
        abort2 = 1'b0;
        chk("t4_abort", {busy2, done2, err_cnt2}, {2'b00, 3'd7});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
